// File: rtl/tb_scoreboard.sv
// Multi-channel in-order scoreboard: per-channel expected FIFOs, head timeouts,
// saturating pass/fail/total counters, sticky per-channel fail flags and a report.
module tb_scoreboard #(
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned TIMEOUT     = 1000,
    parameter bit          DIE_ON_FAIL = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       exp_valid,
    input  logic [CHANNELS*WIDTH-1:0] exp_data,
    output logic [CHANNELS-1:0]       exp_ready,
    input  logic [CHANNELS-1:0]       act_valid,
    input  logic [CHANNELS*WIDTH-1:0] act_data,
    input  logic                      report,
    output logic [31:0]               tot_count,
    output logic [31:0]               pass_count,
    output logic [31:0]               fail_count,
    output logic [CHANNELS-1:0]       fail_chan,
    output logic                      fail_any,
    output logic                      idle
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned EVN_W = $clog2(CHANNELS + 1) + 1;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_PASS,
        EV_MISMATCH,
        EV_UNEXPECTED,
        EV_OVERFLOW,
        EV_TIMEOUT
    } ev_e;

    logic [WIDTH-1:0] mem_q    [CHANNELS][DEPTH];
    logic [WIDTH-1:0] mem_d    [CHANNELS][DEPTH];
    logic [PTR_W-1:0] rd_ptr_q [CHANNELS];
    logic [PTR_W-1:0] rd_ptr_d [CHANNELS];
    logic [PTR_W-1:0] wr_ptr_q [CHANNELS];
    logic [PTR_W-1:0] wr_ptr_d [CHANNELS];
    logic [CNT_W-1:0] occ_q    [CHANNELS];
    logic [CNT_W-1:0] occ_d    [CHANNELS];
    logic [31:0]      wait_q   [CHANNELS];
    logic [31:0]      wait_d   [CHANNELS];

    logic [CHANNELS-1:0] ready_q, ready_d;
    logic [CHANNELS-1:0] fail_chan_q, fail_chan_d;
    logic                fail_any_q, fail_any_d;
    logic                idle_q, idle_d;
    logic [31:0]         tot_count_q, tot_count_d;
    logic [31:0]         pass_count_q, pass_count_d;
    logic [31:0]         fail_count_q, fail_count_d;

    ev_e              ev     [CHANNELS];
    logic [WIDTH-1:0] ev_exp [CHANNELS];
    logic [WIDTH-1:0] ev_act [CHANNELS];

    logic [EVN_W-1:0] npass, nfail;
    logic [WIDTH-1:0] exp_c, act_c, head_c;
    logic             empty_c, full_c, tmo_c, pop_c, push_c;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [EVN_W-1:0] n);
        logic [32:0] s;
        s = {1'b0, a} + 33'(n);
        return s[32] ? '1 : s[31:0];
    endfunction

    always_comb begin
        mem_d       = mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        occ_d       = occ_q;
        wait_d      = wait_q;
        ready_d     = ready_q;
        fail_chan_d = fail_chan_q;
        npass       = '0;
        nfail       = '0;
        exp_c       = '0;
        act_c       = '0;
        head_c      = '0;
        empty_c     = 1'b0;
        full_c      = 1'b0;
        tmo_c       = 1'b0;
        pop_c       = 1'b0;
        push_c      = 1'b0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            exp_c   = exp_data[c*WIDTH +: WIDTH];
            act_c   = act_data[c*WIDTH +: WIDTH];
            head_c  = mem_q[c][rd_ptr_q[c]];
            empty_c = (occ_q[c] == '0);
            full_c  = (occ_q[c] == CNT_W'(DEPTH));
            tmo_c   = (TIMEOUT != 0) && !empty_c && (wait_q[c] == 32'(TIMEOUT - 1));
            pop_c   = 1'b0;
            push_c  = 1'b0;
            ev[c]     = EV_NONE;
            ev_exp[c] = exp_c;
            ev_act[c] = act_c;

            // An observed value always beats a timeout on the same channel.
            if (act_valid[c]) begin
                if (!empty_c) begin
                    pop_c     = 1'b1;
                    ev_exp[c] = head_c;
                    ev[c]     = (head_c == act_c) ? EV_PASS : EV_MISMATCH;
                end else if (exp_valid[c]) begin
                    ev[c] = (exp_c == act_c) ? EV_PASS : EV_MISMATCH;
                end else begin
                    ev[c] = EV_UNEXPECTED;
                end
            end else if (tmo_c) begin
                pop_c     = 1'b1;
                ev_exp[c] = head_c;
                ev[c]     = EV_TIMEOUT;
            end

            // Bypass consumes the push; a full FIFO still accepts it when popping.
            if (exp_valid[c] && !(empty_c && act_valid[c])) begin
                if (!full_c || pop_c) begin
                    push_c = 1'b1;
                end else begin
                    ev[c] = EV_OVERFLOW;
                end
            end

            if (push_c) begin
                mem_d[c][wr_ptr_q[c]] = exp_c;
                wr_ptr_d[c]           = wr_ptr_q[c] + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d[c] = rd_ptr_q[c] + PTR_W'(1);
            end
            occ_d[c]   = occ_q[c] + CNT_W'(push_c) - CNT_W'(pop_c);
            wait_d[c]  = (pop_c || empty_c || TIMEOUT == 0) ? '0 : wait_q[c] + 32'd1;
            ready_d[c] = (occ_d[c] != CNT_W'(DEPTH));

            if (ev[c] == EV_PASS) begin
                npass = npass + EVN_W'(1);
            end else if (ev[c] != EV_NONE) begin
                nfail          = nfail + EVN_W'(1);
                fail_chan_d[c] = 1'b1;
            end
        end
        pass_count_d = sat_add(pass_count_q, npass);
        fail_count_d = sat_add(fail_count_q, nfail);
        tot_count_d  = sat_add(sat_add(tot_count_q, npass), nfail);
        fail_any_d   = |fail_chan_d;
        idle_d       = 1'b1;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (occ_d[c] != '0) idle_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                rd_ptr_q[c] <= '0;
                wr_ptr_q[c] <= '0;
                occ_q[c]    <= '0;
                wait_q[c]   <= '0;
            end
            ready_q      <= '1;
            fail_chan_q  <= '0;
            fail_any_q   <= 1'b0;
            idle_q       <= 1'b1;
            tot_count_q  <= '0;
            pass_count_q <= '0;
            fail_count_q <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            occ_q        <= occ_d;
            wait_q       <= wait_d;
            ready_q      <= ready_d;
            fail_chan_q  <= fail_chan_d;
            fail_any_q   <= fail_any_d;
            idle_q       <= idle_d;
            tot_count_q  <= tot_count_d;
            pass_count_q <= pass_count_d;
            fail_count_q <= fail_count_d;
        end
    end

    assign exp_ready  = ready_q;
    assign fail_chan  = fail_chan_q;
    assign fail_any   = fail_any_q;
    assign idle       = idle_q;
    assign tot_count  = tot_count_q;
    assign pass_count = pass_count_q;
    assign fail_count = fail_count_q;

`ifndef SYNTHESIS
    function automatic string kind_str(input ev_e e);
        case (e)
            EV_MISMATCH:   return "mismatch";
            EV_UNEXPECTED: return "unexpected";
            EV_OVERFLOW:   return "overflow";
            EV_TIMEOUT:    return "timeout";
            default:       return "none";
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (ev[c] != EV_NONE && ev[c] != EV_PASS) begin
                    $display("Error: scoreboard ch%0d: %s exp=%h act=%h",
                             c, kind_str(ev[c]), ev_exp[c], ev_act[c]);
                    if (DIE_ON_FAIL) $finish(2);
                end
            end
        end
        if (report) begin
            $display("Assert report:");
            $display("passed %0d/%0d", reset ? 32'd0 : pass_count_d, reset ? 32'd0 : tot_count_d);
            $display("failed %0d/%0d", reset ? 32'd0 : fail_count_d, reset ? 32'd0 : tot_count_d);
            if (reset || tot_count_d == '0)
                $display("Error: Failed! no asserts checked");
            else if (fail_count_d == '0)
                $display("Success! all asserts passed!");
            else
                $display("Error: Failed! bad asserts");
        end
    end
`endif

endmodule

// File: tb/tb_tb_scoreboard.sv
// Randomized bench for tb_scoreboard against a queue/timestamp reference model.
module tb_tb_scoreboard;

    localparam int unsigned CH = 2;
    localparam int unsigned W  = 8;
    localparam int unsigned D  = 4;
    localparam int unsigned TO = 10;
    localparam longint     SAT = 64'hFFFF_FFFF;

    logic              clk;
    logic              reset;
    logic [CH-1:0]     exp_valid;
    logic [CH*W-1:0]   exp_data;
    logic [CH-1:0]     exp_ready;
    logic [CH-1:0]     act_valid;
    logic [CH*W-1:0]   act_data;
    logic              report;
    logic [31:0]       tot_count, pass_count, fail_count;
    logic [CH-1:0]     fail_chan;
    logic              fail_any;
    logic              idle;

    tb_scoreboard #(
        .CHANNELS(CH),
        .WIDTH(W),
        .DEPTH(D),
        .TIMEOUT(TO),
        .DIE_ON_FAIL(1'b0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .exp_valid(exp_valid),
        .exp_data(exp_data),
        .exp_ready(exp_ready),
        .act_valid(act_valid),
        .act_data(act_data),
        .report(report),
        .tot_count(tot_count),
        .pass_count(pass_count),
        .fail_count(fail_count),
        .fail_chan(fail_chan),
        .fail_any(fail_any),
        .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expected queues, time each head became head, result tallies.
    logic [W-1:0] mq [CH][$];
    int           head_since [CH];
    int           now;
    longint       m_pass, m_fail, m_tot;
    logic [CH-1:0] m_fchan;

    int n_cmp = 0;
    int n_bad = 0;

    logic [CH-1:0]   r_ev, r_av;
    logic [CH*W-1:0] r_ed, r_ad;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic longint sat(input longint v);
        return (v > SAT) ? SAT : v;
    endfunction

    task automatic model_step();
        int np, nf;
        np = 0;
        nf = 0;
        now++;
        if (reset) begin
            for (int c = 0; c < CH; c++) mq[c].delete();
            m_pass  = 0;
            m_fail  = 0;
            m_tot   = 0;
            m_fchan = '0;
            return;
        end
        for (int c = 0; c < CH; c++) begin
            logic [W-1:0] e, a;
            bit was_empty, was_full, popped, failed;
            e = exp_data[c*W +: W];
            a = act_data[c*W +: W];
            was_empty = (mq[c].size() == 0);
            was_full  = (mq[c].size() == D);
            popped    = 0;
            failed    = 0;
            if (act_valid[c]) begin
                if (!was_empty) begin
                    if (mq[c][0] == a) np++; else failed = 1;
                    popped = 1;
                end else if (exp_valid[c]) begin
                    if (e == a) np++; else failed = 1;
                end else begin
                    failed = 1;
                end
            end else if (!was_empty && (now - head_since[c]) == TO) begin
                failed = 1;
                popped = 1;
            end
            if (popped) begin
                void'(mq[c].pop_front());
                head_since[c] = now;
            end
            if (exp_valid[c] && !(was_empty && act_valid[c])) begin
                if (!was_full || popped) begin
                    if (mq[c].size() == 0) head_since[c] = now;
                    mq[c].push_back(e);
                end else begin
                    failed = 1;
                end
            end
            if (failed) begin
                nf++;
                m_fchan[c] = 1'b1;
            end
        end
        m_pass = sat(m_pass + np);
        m_fail = sat(m_fail + nf);
        m_tot  = sat(m_tot + np + nf);
    endtask

    task automatic compare_all();
        logic [CH-1:0] rdy;
        logic          all_empty;
        all_empty = 1'b1;
        for (int c = 0; c < CH; c++) begin
            rdy[c] = (mq[c].size() != D);
            if (mq[c].size() != 0) all_empty = 1'b0;
        end
        check("tot_count", 64'(tot_count), 64'(m_tot));
        check("pass_count", 64'(pass_count), 64'(m_pass));
        check("fail_count", 64'(fail_count), 64'(m_fail));
        check("fail_chan", 64'(fail_chan), 64'(m_fchan));
        check("fail_any", 64'(fail_any), 64'(|m_fchan));
        check("idle", 64'(idle), 64'(all_empty));
        check("exp_ready", 64'(exp_ready), 64'(rdy));
    endtask

    task automatic cyc(input logic [CH-1:0] ev, input logic [CH*W-1:0] ed,
                       input logic [CH-1:0] av, input logic [CH*W-1:0] ad,
                       input logic rst, input logic rep);
        exp_valid = ev;
        exp_data  = ed;
        act_valid = av;
        act_data  = ad;
        reset     = rst;
        report    = rep;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc('0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        now = 0;
        for (int c = 0; c < CH; c++) head_since[c] = 0;
        m_pass = 0; m_fail = 0; m_tot = 0; m_fchan = '0;
        exp_valid = '0; exp_data = '0; act_valid = '0; act_data = '0;
        reset = 1'b1; report = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) cyc('0, '0, '0, '0, 1'b1, 1'b0);

        // In-order passes on ch0, then report.
        cyc(2'b01, {8'h00, 8'h11}, 2'b00, '0, 1'b0, 1'b0);
        cyc(2'b01, {8'h00, 8'h22}, 2'b00, '0, 1'b0, 1'b0);
        cyc(2'b00, '0, 2'b01, {8'h00, 8'h11}, 1'b0, 1'b0);
        cyc(2'b00, '0, 2'b01, {8'h00, 8'h22}, 1'b0, 1'b0);
        cyc(2'b00, '0, 2'b00, '0, 1'b0, 1'b1);

        // Mismatch on ch1.
        cyc(2'b10, {8'h33, 8'h00}, 2'b00, '0, 1'b0, 1'b0);
        cyc(2'b00, '0, 2'b10, {8'h34, 8'h00}, 1'b0, 1'b0);

        // Bypass on both channels, then unexpected data on ch0.
        cyc(2'b11, {8'h5A, 8'h5A}, 2'b11, {8'h5A, 8'h5A}, 1'b0, 1'b0);
        cyc(2'b00, '0, 2'b01, {8'h00, 8'h77}, 1'b0, 1'b0);

        // Fill ch0, overflow, push+pop while full, then let timeouts drain it.
        for (int i = 0; i < D; i++) cyc(2'b01, {8'h00, 8'(8'hA0 + i)}, 2'b00, '0, 1'b0, 1'b0);
        cyc(2'b01, {8'h00, 8'hEE}, 2'b00, '0, 1'b0, 1'b0);
        cyc(2'b01, {8'h00, 8'hB0}, 2'b01, {8'h00, 8'hA0}, 1'b0, 1'b0);
        idle_cycles(TO * (D + 1));

        // Timeout exactly at t+TO, then an observation at t+TO wins.
        cyc(2'b01, {8'h00, 8'hC3}, 2'b00, '0, 1'b0, 1'b0);
        idle_cycles(TO);
        cyc(2'b01, {8'h00, 8'hC4}, 2'b00, '0, 1'b0, 1'b0);
        idle_cycles(TO - 1);
        cyc(2'b00, '0, 2'b01, {8'h00, 8'hC4}, 1'b0, 1'b0);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 1500; k++) begin
            for (int c = 0; c < CH; c++) begin
                r_ev[c] = ($urandom_range(99) < 40);
                r_av[c] = ($urandom_range(99) < 45);
                r_ed[c*W +: W] = W'($urandom);
                if (mq[c].size() != 0 && $urandom_range(99) < 85)
                    r_ad[c*W +: W] = mq[c][0];
                else if (r_ev[c] && $urandom_range(99) < 85)
                    r_ad[c*W +: W] = r_ed[c*W +: W];
                else
                    r_ad[c*W +: W] = W'($urandom);
            end
            cyc(r_ev, r_ed, r_av, r_ad, ($urandom_range(399) == 0), 1'b0);
        end

        // Saturation: preload counters near the top and keep passing.
        force dut.tot_count_q = 32'hFFFF_FFFD;
        force dut.pass_count_q = 32'hFFFF_FFFD;
        #1;
        release dut.tot_count_q;
        release dut.pass_count_q;
        m_tot  = 64'hFFFF_FFFD;
        m_pass = 64'hFFFF_FFFD;
        for (int i = 0; i < 3; i++)
            cyc(2'b11, {8'h3C, 8'hC3}, 2'b11, {8'h3C, 8'hC3}, 1'b0, 1'b0);

        // Mid-run reset with five queued entries; nothing may time out afterwards.
        idle_cycles(TO * (D + 1));
        cyc(2'b11, {8'h01, 8'h02}, 2'b00, '0, 1'b0, 1'b0);
        cyc(2'b11, {8'h03, 8'h04}, 2'b00, '0, 1'b0, 1'b0);
        cyc(2'b01, {8'h00, 8'h05}, 2'b00, '0, 1'b0, 1'b0);
        cyc('0, '0, '0, '0, 1'b1, 1'b0);
        idle_cycles(2 * TO);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
